sa_psum_drain: RTL

- Output-side drain for the weight-stationary systolic compute array.
- Accepts the column-skewed partial sums leaving the bottom row of the PE array. Column n of a result vector emerges n cycles after column 0.
- De-skews them into aligned full-width vectors and buffers them in a small FIFO.
- Presents the vectors to the output buffer over a valid/ready handshake. It is the counterpart of the input-side activation skewing done above the array.

---
 rtl/sa_psum_drain.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sa_psum_drain.sv
// sa_psum_drain
//   Output-side drain of the weight-stationary systolic array. Column n of a
//   result vector leaves the bottom PE row n cycles after column 0. Each
//   column is delayed by NUM_COLS-1-n register stages so that every column of a
//   vector lines up. The aligned vectors are queued in a small FIFO and offered
//   to the output buffer over a valid/ready handshake. The skew pipeline never
//   stalls. A vector that arrives while the FIFO is full and nothing is popped
//   is dropped and flagged.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : synchronous flush of skew pipeline, FIFO and overflow flag
//   i_valid     : column 0 of a new vector is on i_psum[0] this cycle
//   i_psum      : skewed bottom-row partial sums, one per column
//   o_valid     : aligned vector available at the FIFO head
//   i_ready     : consumer accepts the head this cycle
//   o_psum      : aligned head vector (all zeros when o_valid is low)
//   o_count     : FIFO occupancy
//   o_busy      : any vector in the skew pipeline or the FIFO
//   o_overflow  : sticky, a vector was dropped because the FIFO was full
module sa_psum_drain #(
  parameter int ADD_DATAWIDTH = 32,
  parameter int NUM_COLS      = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         i_clear,
  input  logic                                         i_valid,
  input  logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0]       i_psum,
  output logic                                         o_valid,
  input  logic                                         i_ready,
  output logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0]       o_psum,
  output logic [$clog2(FIFO_DEPTH):0]                  o_count,
  output logic                                         o_busy,
  output logic                                         o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // vld_p[k] marks that column k of some vector is on i_psum[k] this cycle.
  logic [NUM_COLS-1:0]                   vld_p;
  logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0] aligned_p;

  assign vld_p[0] = i_valid;

  // ---- skew stage: valid tracking ----
  generate
    if (NUM_COLS > 1) begin : g_vld
      logic [NUM_COLS-1:1] vld_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_q <= '0;
        else if (i_clear) vld_q <= '0;
        else              vld_q <= vld_p[NUM_COLS-2:0];
      end
      assign vld_p[NUM_COLS-1:1] = vld_q;
    end
  endgenerate

  // ---- skew stage: per-column deskew delay lines ----
  generate
    for (genvar n = 0; n < NUM_COLS; n++) begin : g_col
      localparam int L = NUM_COLS - 1 - n;
      if (L == 0) begin : g_pass
        assign aligned_p[n] = i_psum[n];
      end else begin : g_dly
        logic [L-1:0][ADD_DATAWIDTH-1:0] skew_p;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            skew_p <= '0;
          end else if (i_clear) begin
            skew_p <= '0;
          end else begin
            skew_p[0] <= i_psum[n];
            for (int s = 1; s < L; s++) skew_p[s] <= skew_p[s-1];
          end
        end
        assign aligned_p[n] = skew_p[L-1];
      end
    end
  endgenerate

  // ---- FIFO stage ----
  logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, full, wr_en;

  assign push  = vld_p[NUM_COLS-1];
  assign pop   = (count != '0) && i_ready;
  assign full  = (count == CW'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (push && !wr_en) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !i_clear) mem[wr_ptr] <= aligned_p;
  end

  assign o_valid = (count != '0);
  assign o_psum  = o_valid ? mem[rd_ptr] : '0;
  assign o_count = count;
  assign o_busy  = (|vld_p) || (count != '0);

endmodule
